lgn_class_scorer: RTL and testbench

Time-multiplexed class-scoring back end for the logic-gate-network classifier. It takes the network's per-category output bits as a stream of CHUNK_W-bit beats and accumulates a popcount per category across beats. It then runs a sequential arg-max scan over the stored sums and presents the winning category index and score through a valid/ready handshake. It replaces the flat combinational popcount and arg-max path, so that more categories and wider categories can be handled without a single large adder tree.

---
 rtl/lgn_pkg.sv | 21 ++
 rtl/lgn_popcount.sv | 18 +
 rtl/lgn_class_scorer.sv | 138 +++++++++++++
 tb/tb_lgn_class_scorer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lgn_pkg.sv
// Shared types and width helper for the class scorer.
// Holds the scorer state encoding and the clog2 (minimum 1) used to size counters and sums.
package lgn_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lgn_popcount.sv
// Combinational popcount of an N-bit chunk; zero latency.
// No handshake: the count follows the input in the same cycle.
module lgn_popcount #(
  parameter int N = 32,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/lgn_class_scorer.sv
// Streamed per-category popcount, then a one-category-per-cycle arg-max; LGN_MARGIN_EN adds out_margin.
// Result valid CATEGORIES cycles after the last beat; in_ready stays low until the result is consumed.
module lgn_class_scorer
  import lgn_pkg::*;
#(
  parameter int CATEGORIES        = 10,
  parameter int BITS_PER_CATEGORY = 800,
  parameter int CHUNK_W           = 32,
  localparam int IDX_W            = clog2_min1(CATEGORIES),
  localparam int SUM_W            = clog2_min1(BITS_PER_CATEGORY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_index,
  output logic [SUM_W-1:0]   out_value
`ifdef LGN_MARGIN_EN
  ,
  output logic [SUM_W-1:0]   out_margin
`endif
);

  localparam int BEATS  = BITS_PER_CATEGORY / CHUNK_W;
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int PC_W   = clog2_min1(CHUNK_W + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_CAT  = IDX_W'(CATEGORIES - 1);

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q;
  logic [IDX_W-1:0]   cat_q;
  logic [IDX_W-1:0]   scan_q;
  logic [SUM_W-1:0]   sums_q [CATEGORIES];
  logic [SUM_W-1:0]   best_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [SUM_W-1:0]   cur_sum;
  logic [PC_W-1:0]    chunk_ones;
  logic               accept, restart, last_beat, last_cat, scan_step, scan_last;

  lgn_popcount #(.N(CHUNK_W)) u_popcount (
    .bits  (in_bits),
    .count (chunk_ones)
  );

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_index = best_idx_q;
  assign out_value = best_q;

  assign accept    = in_valid && in_ready;
  assign restart   = clear || (out_valid && out_ready);
  assign last_beat = (beat_q == LAST_BEAT);
  assign last_cat  = (cat_q == LAST_CAT);
  assign scan_step = (state_q == SCAN) && !clear;
  assign scan_last = (scan_q == LAST_CAT);
  assign cur_sum   = sums_q[scan_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_beat && last_cat) state_d = SCAN;
      SCAN:    if (scan_last) state_d = DONE;
      DONE:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
    if (clear) state_d = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // Clear wins over a same-cycle beat, so restart is tested before accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      cat_q  <= '0;
      for (int i = 0; i < CATEGORIES; i++) sums_q[i] <= '0;
    end else if (restart) begin
      beat_q <= '0;
      cat_q  <= '0;
      for (int i = 0; i < CATEGORIES; i++) sums_q[i] <= '0;
    end else if (accept) begin
      sums_q[cat_q] <= sums_q[cat_q] + SUM_W'(chunk_ones);
      if (last_beat) begin
        beat_q <= '0;
        cat_q  <= last_cat ? '0 : cat_q + 1'b1;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         scan_q <= '0;
    else if (scan_step) scan_q <= scan_last ? '0 : scan_q + 1'b1;
    else                scan_q <= '0;
  end

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q     <= '0;
      best_idx_q <= '0;
    end else if (scan_step) begin
      if (scan_q == '0) begin
        best_q     <= cur_sum;
        best_idx_q <= '0;
      end else if (cur_sum > best_q) begin
        best_q     <= cur_sum;
        best_idx_q <= scan_q;
      end
    end
  end

`ifdef LGN_MARGIN_EN
  logic [SUM_W-1:0] second_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_q <= '0;
    end else if (scan_step) begin
      if (scan_q == '0)              second_q <= '0;
      else if (cur_sum > best_q)     second_q <= best_q;
      else if (cur_sum > second_q)   second_q <= cur_sum;
    end
  end

  assign out_margin = best_q - second_q;
`endif

endmodule

// File: tb/tb_lgn_class_scorer.sv
// Directed bench for lgn_class_scorer (4 categories x 64 bits, 16-bit beats) against a frame-level model.
module tb_lgn_class_scorer;

  localparam int C   = 4;
  localparam int BPC = 64;
  localparam int CW  = 16;
  localparam int NB  = BPC / CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_bits = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [1:0]    out_index;
  logic [6:0]    out_value;
`ifdef LGN_MARGIN_EN
  logic [6:0]    out_margin;
`endif

  int total = 0;
  int bad   = 0;

  lgn_class_scorer #(.CATEGORIES(C), .BITS_PER_CATEGORY(BPC), .CHUNK_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_value (out_value)
`ifdef LGN_MARGIN_EN
    ,
    .out_margin(out_margin)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase 0 collecting beats, 1 scanning, 2 result pending.
  int m_phase = 0;
  int m_beats = 0;
  int m_cnt   = 0;
  int msum [C] = '{default: 0};
  int e_idx = 0, e_val = 0, e_mar = 0;

  task automatic model_winner();
    int second;
    e_val = -1;
    for (int i = 0; i < C; i++) if (msum[i] > e_val) begin e_val = msum[i]; e_idx = i; end
    second = 0;
    for (int i = 0; i < C; i++) if (i != e_idx && msum[i] > second) second = msum[i];
    e_mar = e_val - second;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      m_phase = 0; m_beats = 0; m_cnt = 0;
      for (int i = 0; i < C; i++) msum[i] = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             msum[m_beats / NB] += $countones(in_bits);
             m_beats++;
             if (m_beats == C * NB) begin m_phase = 1; m_cnt = 0; end
           end
        1: begin
             m_cnt++;
             if (m_cnt == C) begin m_phase = 2; model_winner(); end
           end
        default: if (out_ready) begin
             m_phase = 0; m_beats = 0;
             for (int i = 0; i < C; i++) msum[i] = 0;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(m_phase == 0));
    chk("out_valid", int'(out_valid), int'(m_phase == 2));
    if (m_phase == 2) begin
      chk("model_index", int'(out_index), e_idx);
      chk("model_value", int'(out_value), e_val);
`ifdef LGN_MARGIN_EN
      chk("model_margin", int'(out_margin), e_mar);
`endif
    end
  end

  function automatic logic [CW-1:0] mk(input int k, input int r);
    logic [CW-1:0] v;
    int s;
    v = (k >= CW) ? '1 : CW'((32'd1 << k) - 1);
    s = r % CW;
    return (v << s) | (v >> (CW - s));
  endfunction

  task automatic send_beat(input logic [CW-1:0] d);
    logic acc;
    int n;
    in_valid = 1'b1;
    in_bits  = d;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin chk("beat_accept_timeout", 0, 1); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d);
    int cnt [C];
    int k;
    cnt = '{a, b, c, d};
    for (int cat = 0; cat < C; cat++)
      for (int bt = 0; bt < NB; bt++) begin
        k = cnt[cat] / NB + ((bt < cnt[cat] % NB) ? 1 : 0);
        send_beat(mk(k, cat * 5 + bt * 3));
      end
  endtask

  task automatic run_frame(input int a, input int b, input int c, input int d,
                           input int xi, input int xv, input int xm);
    int lat;
    send_frame(a, b, c, d);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, C);
    chk("index", int'(out_index), xi);
    chk("value", int'(out_value), xv);
`ifdef LGN_MARGIN_EN
    chk("margin", int'(out_margin), xm);
`else
    if (xm < 0) chk("margin_arg", xm, 0);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_value", int'(out_value), 0);

    run_frame(10, 60, 30, 5, 1, 60, 30);
    run_frame(40, 0, 40, 0, 0, 40, 0);
    run_frame(0, 0, 0, 64, 3, 64, 64);

    // Result held back while the source keeps offering beats.
    out_ready = 1'b0;
    run_frame(5, 6, 7, 8, 3, 8, 1);
    in_valid = 1'b1;
    in_bits  = '1;
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_index", int'(out_index), 3);
      chk("stall_value", int'(out_value), 8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_hs_valid", int'(out_valid), 0);
    chk("post_hs_ready", int'(in_ready), 1);
    run_frame(2, 9, 9, 1, 1, 9, 0);

    // Abort a partial frame; the clear cycle also carries a beat that must be dropped.
    for (int i = 0; i < 7; i++) send_beat('1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_bits  = '1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    run_frame(3, 4, 20, 2, 2, 20, 16);

    // Reset in the middle of the scan.
    send_frame(1, 1, 1, 1);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midscan_rst_valid", int'(out_valid), 0);
    chk("midscan_rst_ready", int'(in_ready), 1);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_valid", int'(out_valid), 0);
    chk("after_rst_ready", int'(in_ready), 1);
    run_frame(1, 2, 3, 4, 3, 4, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule
